// File: rtl/fpadd_selftest.sv
// fpadd_selftest: ROM-driven self-test sequencer for an external floating-point adder.
// Build option FPADD_SELFTEST_NAN_EQ_EN: in CHECK, any NaN result matches any NaN expectation.
module fpadd_selftest #(
  parameter int NUM = 10,
  parameter int LAT = 2,
  parameter int AW  = 8
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  output logic [AW-1:0] vec_addr,
  input  logic [95:0]   vec_data,
  output logic [31:0]   reg_A,
  output logic [31:0]   reg_B,
  input  logic [31:0]   out_sum,
  output logic          busy,
  output logic          done,
  output logic          pass,
  output logic [7:0]    err_count,
  output logic [AW-1:0] err_idx
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_APPLY,
    S_WAIT,
    S_CHECK,
    S_DONE
  } state_t;

  localparam logic [AW-1:0] LAST      = AW'(NUM - 1);
  localparam logic [3:0]    WAIT_LAST = 4'(LAT - 1);

  state_t        state, state_nxt;
  logic [AW-1:0] index;
  logic [31:0]   expected;
  logic [3:0]    wait_cnt;
  logic          err_seen;
  logic          match;

`ifdef FPADD_SELFTEST_NAN_EQ_EN
  logic sum_nan, exp_nan;
  assign sum_nan = (out_sum[30:23] == 8'hFF) && (out_sum[22:0] != '0);
  assign exp_nan = (expected[30:23] == 8'hFF) && (expected[22:0] != '0);
  assign match   = (out_sum == expected) || (sum_nan && exp_nan);
`else
  assign match = (out_sum == expected);
`endif

  assign vec_addr = index;
  assign pass     = done && (err_count == '0);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= S_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    busy      = 1'b1;
    done      = 1'b0;
    case (state)
      S_IDLE: begin
        busy = 1'b0;
        if (start) state_nxt = S_FETCH;
      end
      S_FETCH: state_nxt = S_APPLY;
      S_APPLY: state_nxt = S_WAIT;
      S_WAIT:  if (wait_cnt == WAIT_LAST) state_nxt = S_CHECK;
      S_CHECK: state_nxt = (index == LAST) ? S_DONE : S_FETCH;
      S_DONE: begin
        busy = 1'b0;
        done = 1'b1;
        if (start) state_nxt = S_FETCH;
      end
      default: begin
        busy      = 1'b0;
        state_nxt = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      index     <= '0;
      reg_A     <= '0;
      reg_B     <= '0;
      expected  <= '0;
      wait_cnt  <= '0;
      err_count <= '0;
      err_idx   <= '0;
      err_seen  <= 1'b0;
    end else begin
      case (state)
        S_IDLE, S_DONE: begin
          if (start) begin
            index     <= '0;
            err_count <= '0;
            err_idx   <= '0;
            err_seen  <= 1'b0;
          end
        end
        S_APPLY: begin
          reg_A    <= vec_data[95:64];
          reg_B    <= vec_data[63:32];
          expected <= vec_data[31:0];
          wait_cnt <= '0;
        end
        S_WAIT: wait_cnt <= wait_cnt + 4'd1;
        S_CHECK: begin
          if (!match) begin
            if (err_count != 8'hFF) err_count <= err_count + 8'd1;
            if (!err_seen) begin
              err_seen <= 1'b1;
              err_idx  <= index;
            end
          end
          // index stays at the last vector in DONE so vec_addr keeps tracking it
          if (index != LAST) index <= index + AW'(1);
        end
        default: ;
      endcase
    end
  end

endmodule

// File: doc/fpadd_selftest.md
FPADD_SELFTEST -- requirements
Module: fpadd_selftest

Interface
REQ-001 Parameter NUM, default 10: number of test vectors in the vector ROM, range 1..256.
REQ-002 Parameter LAT, default 2: adder latency in clock edges from a reg_A/reg_B update to a valid out_sum, range 1..15.
REQ-003 Parameter AW, default 8: vector address width; NUM SHALL NOT exceed 2^AW.
REQ-004 clk  input  1  single clock; all state changes on rising edge.
REQ-005 reset  input  1  asynchronous, active-low reset.
REQ-006 start  input  1  request a test run; sampled in IDLE or DONE only.
REQ-007 vec_addr  output  AW  vector ROM read address.
REQ-008 vec_data  input  96  ROM word {A[95:64], B[63:32], expected[31:0]}, valid one cycle after vec_addr.
REQ-009 reg_A  output  32  adder operand A.
REQ-010 reg_B  output  32  adder operand B.
REQ-011 out_sum  input  32  adder result.
REQ-012 busy  output  1  high in every state except IDLE and DONE.
REQ-013 done  output  1  high while in DONE.
REQ-014 pass  output  1  done and err_count equal to zero.
REQ-015 err_count  output  8  mismatch count, saturating at 255.
REQ-016 err_idx  output  AW  index of the first mismatching vector.

Function
REQ-017 The FSM SHALL have states IDLE, FETCH, APPLY, WAIT, CHECK and DONE, held in registers.
REQ-018 IDLE/DONE with start=1 -> FETCH; index, err_count, err_idx and the first-error flag are cleared on the same edge.
REQ-019 FETCH drives vec_addr=index for one cycle, then goes to APPLY.
REQ-020 On the APPLY exit edge, reg_A, reg_B and an internal expected register load from vec_data; next state is WAIT.
REQ-021 WAIT lasts exactly LAT cycles, counted by a 4-bit counter, then goes to CHECK.
REQ-022 CHECK compares out_sum with expected bit-exactly; on mismatch err_count increments (saturating) and, if this is the first mismatch, err_idx loads index.
REQ-023 CHECK with index==NUM-1 -> DONE; otherwise index increments and the FSM goes to FETCH.
REQ-024 Each vector takes LAT+3 cycles; a full run takes NUM*(LAT+3) cycles from start to done.
REQ-025 reg_A and reg_B hold their last values in all states other than APPLY.
REQ-026 start while busy SHALL be ignored.
REQ-027 DONE is held, with all results stable, until a new start or reset.
REQ-028 vec_addr SHALL equal index in all states.

Reset
REQ-029 While reset=0: state=IDLE and index, vec_addr, reg_A, reg_B, expected, err_count, err_idx, busy, done and pass are all 0, independent of clk.
REQ-030 Reset asserted mid-run SHALL abort the run immediately; after release, the block waits in IDLE for start.

Configuration
REQ-031 With FPADD_SELFTEST_NAN_EQ_EN defined, CHECK treats out_sum and expected as a match when both are NaN (exponent 0xFF, mantissa nonzero), regardless of sign and payload.
REQ-032 Without FPADD_SELFTEST_NAN_EQ_EN, all comparisons are bit-exact, including NaN.

Verification
REQ-033 NUM=2, LAT=2, ROM {3f800000,3f800000,40000000},{40400000,bf800000,40000000}, behavioural correct adder -> done after 10 cycles, pass=1, err_count=0.
REQ-034 Same ROM with vector 1 expected changed to 40000001 -> err_count=1, err_idx=1, pass=0.
REQ-035 start pulsed again in cycle 3 of a run -> no restart; done still asserts at cycle 10.
REQ-036 reset pulled low during WAIT of vector 1 -> all outputs 0 asynchronously, state IDLE; a new start then completes a full, correct run.
REQ-037 out_sum=7fc00001, expected=7fc00000 -> match with FPADD_SELFTEST_NAN_EQ_EN, err_count=1 without it.
REQ-038 NUM=256, every expected value wrong -> err_count=255 (saturated), err_idx=0.
